// File: rtl/clusterv_pkg.sv
// Shared ClusterV definitions: FSM encodings and
// address slice bounds for the Wishbone SRAM target.
package clusterv_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;

  // Byte address bits that form the word index.
  localparam int WA_LO = 2;
  localparam int WA_HI = 13;

endpackage

// File: rtl/clusterv_wb_sram_tgt.sv
// Wishbone classic target in front of a sync SRAM.
// Ports: clock/reset, Wishbone t_* target, sram_* macro side.
module clusterv_wb_sram_tgt
  import clusterv_pkg::*;
#(
  parameter int ADR_WIDTH     = 32,
  parameter int DAT_WIDTH     = 32,
  parameter int MEM_ADR_WIDTH = 11,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADR_WIDTH-1:0]     t_adr,
  input  logic [DAT_WIDTH-1:0]     t_dat_w,
  output logic [DAT_WIDTH-1:0]     t_dat_r,
  input  logic                     t_cyc,
  input  logic                     t_stb,
  input  logic                     t_we,
  input  logic [3:0]               t_sel,
  output logic                     t_ack,
  output logic                     t_err,
  input  logic [3:0]               t_tgc,
  input  logic                     t_tga,
  input  logic                     t_tgd_w,
  output logic                     t_tgd_r,
  output logic                     sram_en,
  output logic [3:0]               sram_wmask,
  output logic [MEM_ADR_WIDTH-1:0] sram_addr,
  output logic [31:0]              sram_wdata,
  input  logic [31:0]              sram_rdata
);

  logic [1:0] state;
  logic [1:0] cnt;

  logic [WA_HI-WA_LO:0] wadr;
  logic                 bad;
  logic                 accept;
  logic                 wr_go;
  logic                 rd_go;
  logic                 err_go;
  logic                 unused_tags;

  assign unused_tags = ^{t_tgc, t_tga, t_tgd_w, t_adr};

  assign wadr = t_adr[WA_HI:WA_LO];
  assign bad  = (t_adr[1:0] != 2'b00) ||
                (32'(wadr) >= (32'd1 << MEM_ADR_WIDTH));

  // Gated by reset so the SRAM strobe stays low
  // while the block is held in reset.
  assign accept = reset && (state == ST_IDLE) &&
                  t_cyc && t_stb && !t_ack && !t_err;

  assign err_go = accept && bad;
  assign wr_go  = accept && !bad && t_we;
  assign rd_go  = accept && !bad && !t_we;

  // An all-zero select still gets acked but
  // must not touch the macro.
  assign sram_en    = rd_go || (wr_go && (t_sel != 4'h0));
  assign sram_wmask = wr_go ? t_sel : 4'h0;
  assign sram_addr  = t_adr[MEM_ADR_WIDTH+1:2];
  assign sram_wdata = t_dat_w;
  assign t_tgd_r    = 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      t_ack   <= 1'b0;
      t_err   <= 1'b0;
      t_dat_r <= '0;
    end else begin
      t_ack <= 1'b0;
      t_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (err_go) begin
            state   <= ST_RESP;
            t_err   <= 1'b1;
            t_dat_r <= '0;
          end else if (wr_go) begin
            state <= ST_RESP;
            t_ack <= 1'b1;
          end else if (rd_go) begin
            state <= ST_RD_WAIT;
            cnt   <= 2'(READ_LATENCY - 1);
          end
        end
        ST_RD_WAIT: begin
          if (!t_cyc) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
          end else if (cnt == 2'd0) begin
            state   <= ST_RESP;
            t_ack   <= 1'b1;
            t_dat_r <= sram_rdata;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/clusterv_wb_sram_tgt.md
CLUSTERV_WB_SRAM_TGT -- requirements
Module: clusterv_wb_sram_tgt

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
- ADR_WIDTH, 32, Wishbone address width.
- DAT_WIDTH, 32, Wishbone data width; only 32 is supported.
- MEM_ADR_WIDTH, 11, SRAM word-address width (2048 words = 8 KiB).
- READ_LATENCY, 1, SRAM read latency in clocks; legal values are 1 and 2.
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
- clock, in, 1, the single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- t_adr, in, ADR_WIDTH, byte address.
- t_dat_w, in, DAT_WIDTH, write data.
- t_dat_r, out, DAT_WIDTH, read data.
- t_cyc, in, 1, bus cycle.
- t_stb, in, 1, strobe.
- t_we, in, 1, write enable.
- t_sel, in, 4, byte selects.
- t_ack, out, 1, normal termination.
- t_err, out, 1, error termination.
- t_tgc, in, 4, cycle tag; ignored.
- t_tga, in, 1, address tag; ignored.
- t_tgd_w, in, 1, data tag; ignored.
- t_tgd_r, out, 1, read data tag; tied to 0.
- sram_en, out, 1, SRAM access strobe.
- sram_wmask, out, 4, byte write mask (0 means read).
- sram_addr, out, MEM_ADR_WIDTH, SRAM word address.
- sram_wdata, out, 32, SRAM write data.
- sram_rdata, in, 32, SRAM read data.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RD_WAIT and RESP.
REQ-004 In IDLE, a request SHALL be accepted when t_cyc & t_stb & !t_ack & !t_err; the cycle in which this holds is cycle 0.
REQ-005 An accepted request SHALL be an error when t_adr[1:0] != 0 or t_adr[13:2] >= 2**MEM_ADR_WIDTH; an error issues no SRAM access and moves to RESP with t_err=1 visible in cycle 1.
REQ-006 An accepted write with no error SHALL, in cycle 0:
- drive sram_en=1, sram_wmask=t_sel, sram_addr=t_adr[MEM_ADR_WIDTH+1:2] and sram_wdata=t_dat_w, all combinationally;
- move to RESP, with t_ack=1 visible in cycle 1.
REQ-007 A write with t_sel=0 SHALL still be acknowledged, and SHALL drive sram_en=0.
REQ-008 An accepted read with no error SHALL, in cycle 0:
- drive sram_en=1 and sram_wmask=0;
- move to RD_WAIT and load the latency counter with READ_LATENCY-1.
REQ-009 In RD_WAIT, the latency counter SHALL decrement each cycle. When it is 0, sram_rdata SHALL be registered into t_dat_r and the FSM SHALL move to RESP, giving t_ack=1 in cycle READ_LATENCY+1.
REQ-010 RESP SHALL last exactly one cycle, with exactly one of t_ack or t_err high; the next state is always IDLE.
REQ-011 The acknowledge SHALL NOT be combinational from t_stb, and a back-to-back request SHALL be accepted no earlier than the cycle after RESP.
REQ-012 t_dat_r SHALL hold its last value outside RESP, and SHALL be 0 on error responses.
REQ-013 If t_cyc falls while in RD_WAIT, the FSM SHALL return to IDLE, with no ack and t_dat_r unchanged.
REQ-014 If t_cyc is low in RESP, t_ack and t_err SHALL still pulse for that cycle; the initiator ignores them.
REQ-015 sram_en SHALL be asserted only in an accepting IDLE cycle, and never in RD_WAIT or RESP.

Reset
REQ-016 While reset=0, the block SHALL hold: state=IDLE, latency counter=0, t_ack=0, t_err=0, t_dat_r=0, sram_en=0, sram_wmask=0, t_tgd_r=0.
REQ-017 Reset asserted mid-transaction SHALL abort it with no ack; the first request after release SHALL be accepted normally.

Structure
REQ-018 The state encoding (IDLE=2'd0, RD_WAIT=2'd1, RESP=2'd2) SHALL live in the shared package clusterv_pkg.
REQ-019 The word-address slice constant SHALL also live in clusterv_pkg.
REQ-020 The block SHALL contain no sub-module; the SRAM macro is instantiated by the parent.

Verification
REQ-021 Write test: write adr=0x8000_0010, dat=0xDEAD_BEEF, sel=0xF -> sram_addr=4, wmask=0xF in cycle 0; t_ack in cycle 1.
REQ-022 Read test: read adr=0x8000_0010 with the SRAM model returning 0xDEAD_BEEF, for READ_LATENCY=1 and then 2 -> t_dat_r=0xDEAD_BEEF with t_ack in cycle 2 and cycle 3 respectively.
REQ-023 Error test: read adr=0x8000_0012 -> t_err in cycle 1, sram_en never high; read adr=0x8000_2000 (MEM_ADR_WIDTH=11) -> t_err in cycle 1.
REQ-024 Byte-write test: write sel=0x4, dat=0x00AB_0000, then read back -> byte 2=0xAB and other bytes unchanged; a write with sel=0 -> ack in cycle 1 and sram_en=0.
REQ-025 Abort test: READ_LATENCY=2, drop t_cyc in cycle 1 -> no ack, FSM in IDLE by cycle 2; then reset=0 in RD_WAIT -> all outputs 0 and the next read completes normally.
